// File: rtl/result_readback_unit_pkg.sv
// ============================================================================
// Module      : result_readback_unit_pkg
// Description : Shared constants for the result read-back path: host route
//               value, FIFO depth, register offsets and STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_readback_unit_pkg;

    // Route field value (address MSBs) that selects the read-back block
    localparam logic [1:0] RouteResult       = 2'b10;

    // Default number of result FIFO entries (power of two, at least 2)
    localparam int         ResultBufferDepth = 16;

    // Register offsets inside the block (AddressIn[1:0])
    localparam logic [1:0] OffResult         = 2'd0;
    localparam logic [1:0] OffStatus         = 2'd1;
    localparam logic [1:0] OffTotal          = 2'd2;
    localparam logic [1:0] OffReserved       = 2'd3;

    // STATUS word bit positions
    localparam int         StatusEmptyBit    = 16;
    localparam int         StatusFullBit     = 17;
    localparam int         StatusOvfBit      = 18;
    localparam int         StatusUdfBit      = 19;

endpackage

`default_nettype wire

// File: rtl/result_readback_unit_result_fifo.sv
// ============================================================================
// Module      : result_fifo
// Description : Synchronous FIFO holding MAC result words. Count is kept as a
//               separate register (0..Depth); pointers wrap naturally. A push
//               on full is accepted only when a pop frees a slot in the same
//               cycle. The head word is presented combinationally on dout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo #(
    parameter int Width     = 32,
    parameter int Depth     = 16,
    parameter int CountBits = $clog2(Depth) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [Width-1:0]     din,
    output logic [Width-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [CountBits-1:0] count
);

    localparam int PtrBits = $clog2(Depth);

    logic [Width-1:0]     mem_q [Depth];
    logic [PtrBits-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrBits-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountBits-1:0] count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_q == CountBits'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // A pop on empty is meaningless; a pop on full opens a slot for the push
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrBits'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrBits'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CountBits'(1);
                2'b01:   count_d = count_q - CountBits'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are never cleared, only the pointers
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/result_readback_unit.sv
// ============================================================================
// Module      : result_readback_unit
// Description : Host-facing read side of the accelerator. Queues MAC results
//               in a FIFO and serves them over the host bus, together with a
//               STATUS word (count/empty/full/ovf/udf) and a TOTAL counter of
//               accepted results. DataOut is registered, one cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_readback_unit
    import result_readback_unit_pkg::*;
#(
    parameter int DataBitWidth    = 32,
    parameter int AddressBitWidth = 8,
    parameter int AddrRoutingBits = 2,
    parameter int ResultDepth     = ResultBufferDepth,
    parameter int CountBits       = $clog2(ResultDepth) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmdReset,
    input  logic                       ResultValidIn,
    input  logic [DataBitWidth-1:0]    ResultIn,
    output logic                       ResultReadyOut,
    input  logic                       ReadEnIn,
    input  logic                       WriteEnIn,
    input  logic [AddressBitWidth-1:0] AddressIn,
    input  logic [DataBitWidth-1:0]    DataIn,
    output logic [DataBitWidth-1:0]    DataOut,
    output logic                       ResultAvailOut
);

    logic [AddrRoutingBits-1:0] route;
    logic [1:0]                 off;
    logic                       selected;
    logic                       host_rd;
    logic                       host_wr;
    logic                       pop_req;

    logic [DataBitWidth-1:0]    fifo_dout;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CountBits-1:0]       fifo_count;

    logic                       ovf_set;
    logic                       udf_set;
    logic                       push_accepted;

    logic                       ovf_q, ovf_d;
    logic                       udf_q, udf_d;
    logic [DataBitWidth-1:0]    total_q, total_d;
    logic [DataBitWidth-1:0]    dout_q, dout_d;
    logic [DataBitWidth-1:0]    status_word;

    logic                       unused_inputs;

    assign route    = AddressIn[AddressBitWidth-1 -: AddrRoutingBits];
    assign off      = AddressIn[1:0];
    assign selected = (route == AddrRoutingBits'(RouteResult));
    // A read wins over a simultaneous write
    assign host_rd  = selected && ReadEnIn;
    assign host_wr  = selected && WriteEnIn && !ReadEnIn;
    assign pop_req  = host_rd && (off == OffResult);

    // Mirrors the FIFO acceptance rule so ovf and TOTAL stay consistent with it
    assign push_accepted = ResultValidIn && (!fifo_full || (pop_req && !fifo_empty));
    assign ovf_set       = ResultValidIn && !push_accepted;
    assign udf_set       = pop_req && fifo_empty;

    assign unused_inputs = ^{DataIn[DataBitWidth-1:StatusUdfBit+1],
                             DataIn[StatusOvfBit-1:0],
                             AddressIn[AddressBitWidth-AddrRoutingBits-1:2]};

    result_fifo #(
        .Width     (DataBitWidth),
        .Depth     (ResultDepth),
        .CountBits (CountBits)
    ) u_result_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (cmdReset),
        .push  (ResultValidIn),
        .pop   (pop_req),
        .din   (ResultIn),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ResultReadyOut = !fifo_full;
    assign ResultAvailOut = !fifo_empty;
    assign DataOut        = dout_q;

    // Assemble the STATUS word from pre-update state
    always_comb begin
        status_word                 = '0;
        status_word[CountBits-1:0]  = fifo_count;
        status_word[StatusEmptyBit] = fifo_empty;
        status_word[StatusFullBit]  = fifo_full;
        status_word[StatusOvfBit]   = ovf_q;
        status_word[StatusUdfBit]   = udf_q;
    end

    // Next-state for flags, TOTAL counter and read data register
    always_comb begin
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        total_d = total_q;
        dout_d  = dout_q;
        if (cmdReset) begin
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
            total_d = '0;
            dout_d  = '0;
        end else begin
            // Write-1-to-clear first, so a same-cycle set event wins
            if (host_wr && (off == OffStatus)) begin
                if (DataIn[StatusOvfBit]) ovf_d = 1'b0;
                if (DataIn[StatusUdfBit]) udf_d = 1'b0;
            end
            if (ovf_set) ovf_d = 1'b1;
            if (udf_set) udf_d = 1'b1;
            if (push_accepted) total_d = total_q + DataBitWidth'(1);
            if (host_rd) begin
                case (off)
                    OffResult: dout_d = fifo_empty ? '0 : fifo_dout;
                    OffStatus: dout_d = status_word;
                    OffTotal:  dout_d = total_q;
                    default:   dout_d = '0;
                endcase
            end
        end
    end

    // Flag, counter and read data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            total_q <= '0;
            dout_q  <= '0;
        end else begin
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            total_q <= total_d;
            dout_q  <= dout_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_result_readback_unit.sv
// ============================================================================
// Module      : tb_result_readback_unit
// Description : Directed self-checking bench for result_readback_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_readback_unit;

    localparam logic [7:0] c_base = 8'h80;  // route field 2'b10

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdReset;
    logic        ResultValidIn;
    logic [31:0] ResultIn;
    logic        ResultReadyOut;
    logic        ReadEnIn;
    logic        WriteEnIn;
    logic [7:0]  AddressIn;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        ResultAvailOut;

    int n_checks = 0;
    int n_pass   = 0;

    result_readback_unit dut (
        .clk            (clk),
        .reset          (reset),
        .cmdReset       (cmdReset),
        .ResultValidIn  (ResultValidIn),
        .ResultIn       (ResultIn),
        .ResultReadyOut (ResultReadyOut),
        .ReadEnIn       (ReadEnIn),
        .WriteEnIn      (WriteEnIn),
        .AddressIn      (AddressIn),
        .DataIn         (DataIn),
        .DataOut        (DataOut),
        .ResultAvailOut (ResultAvailOut)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        ResultValidIn = 1'b1;
        ResultIn      = w;
        tick();
        ResultValidIn = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] off, output logic [31:0] data);
        AddressIn = c_base | {6'd0, off};
        ReadEnIn  = 1'b1;
        tick();
        ReadEnIn  = 1'b0;
        data      = DataOut;
    endtask

    task automatic host_write(input logic [1:0] off, input logic [31:0] d);
        AddressIn = c_base | {6'd0, off};
        DataIn    = d;
        WriteEnIn = 1'b1;
        tick();
        WriteEnIn = 1'b0;
    endtask

    task automatic soft_clear();
        cmdReset = 1'b1;
        tick();
        cmdReset = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        reset = 1'b0; cmdReset = 1'b0; ResultValidIn = 1'b0; ResultIn = '0;
        ReadEnIn = 1'b0; WriteEnIn = 1'b0; AddressIn = '0; DataIn = '0;

        // Reset state
        #12;
        check_value("reset_dataout", DataOut, 32'h0);
        check_value("reset_ready",   {31'd0, ResultReadyOut}, 32'h1);
        check_value("reset_avail",   {31'd0, ResultAvailOut}, 32'h0);
        reset = 1'b1;
        tick();

        // 1: three pushes, status, ordered reads
        push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
        check_value("t1_avail", {31'd0, ResultAvailOut}, 32'h1);
        host_read(2'd1, rd); check_value("t1_status3", rd, 32'h0000_0003);
        host_read(2'd0, rd); check_value("t1_rd0", rd, 32'hA1);
        host_read(2'd0, rd); check_value("t1_rd1", rd, 32'hA2);
        host_read(2'd0, rd); check_value("t1_rd2", rd, 32'hA3);
        tick();              check_value("t1_hold", DataOut, 32'hA3);
        host_read(2'd1, rd); check_value("t1_status_empty", rd, 32'h0001_0000);
        host_read(2'd3, rd); check_value("t1_reserved", rd, 32'h0);

        // 2: overflow with 17 pushes
        soft_clear();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_value("t2_ready_before_16th", {31'd0, ResultReadyOut}, 32'h1);
            push_word(32'h100 + 32'(i));
        end
        check_value("t2_ready_full", {31'd0, ResultReadyOut}, 32'h0);
        push_word(32'hDEAD);
        host_read(2'd1, rd); check_value("t2_status_ovf", rd, 32'h0006_0010);
        host_read(2'd2, rd); check_value("t2_total", rd, 32'd16);
        host_write(2'd1, 32'h0004_0000);
        host_read(2'd1, rd); check_value("t2_ovf_cleared", rd, 32'h0002_0010);

        // 4: push and pop together on full
        ResultValidIn = 1'b1; ResultIn = 32'hBB;
        AddressIn = c_base; ReadEnIn = 1'b1;
        tick();
        ResultValidIn = 1'b0; ReadEnIn = 1'b0;
        check_value("t4_pop_oldest", DataOut, 32'h100);
        host_read(2'd1, rd); check_value("t4_status_full_no_ovf", rd, 32'h0002_0010);
        for (int i = 1; i < 16; i++) begin
            host_read(2'd0, rd);
            check_value("t4_drain", rd, 32'h100 + 32'(i));
        end
        host_read(2'd0, rd); check_value("t4_bb_last", rd, 32'hBB);

        // 3: read on empty
        host_read(2'd0, rd); check_value("t3_empty_read", rd, 32'h0);
        host_read(2'd1, rd); check_value("t3_status_udf", rd, 32'h0009_0000);
        host_write(2'd1, 32'h0008_0000);
        host_read(2'd1, rd); check_value("t3_udf_cleared", rd, 32'h0001_0000);

        // Push and pop together when empty: no fall-through
        host_read(2'd1, rd);  // DataOut nonzero before the empty pop
        ResultValidIn = 1'b1; ResultIn = 32'hCC;
        AddressIn = c_base; ReadEnIn = 1'b1;
        tick();
        ResultValidIn = 1'b0; ReadEnIn = 1'b0;
        check_value("empty_pushpop_data", DataOut, 32'h0);
        host_read(2'd1, rd); check_value("empty_pushpop_status", rd, 32'h0008_0001);
        host_read(2'd0, rd); check_value("empty_pushpop_word", rd, 32'hCC);

        // 5: soft clear with 4 queued words
        for (int i = 0; i < 4; i++) push_word(32'h200 + 32'(i));
        soft_clear();
        check_value("t5_dataout", DataOut, 32'h0);
        check_value("t5_avail",   {31'd0, ResultAvailOut}, 32'h0);
        host_read(2'd1, rd); check_value("t5_status", rd, 32'h0001_0000);
        host_read(2'd2, rd); check_value("t5_total", rd, 32'h0);

        // 6: asynchronous reset in the middle of a pop
        push_word(32'hC1); push_word(32'hC2);
        host_read(2'd0, rd); check_value("t6_pre", rd, 32'hC1);
        AddressIn = c_base; ReadEnIn = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_value("t6_async_dataout", DataOut, 32'h0);
        ReadEnIn = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        tick();
        check_value("t6_ready", {31'd0, ResultReadyOut}, 32'h1);
        check_value("t6_avail", {31'd0, ResultAvailOut}, 32'h0);
        host_read(2'd1, rd); check_value("t6_status", rd, 32'h0001_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
